// File: rtl/ttt_board_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ttt_board_ctrl_pkg
// Shared definitions for the tic-tac-toe board controller and the win/tie
// checker that sits beside it: cell codes, outcome codes, controller state
// encoding, cell index constants and a small player-toggle helper.
// -----------------------------------------------------------------------------
package ttt_board_ctrl_pkg;

  // Cell contents / player codes
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // Outcome codes reported by the checker
  localparam logic [2:0] OUT_IN_PROGRESS = 3'd0;
  localparam logic [2:0] OUT_P1_WIN      = 3'd1;
  localparam logic [2:0] OUT_P1_LOSE     = 3'd2;
  localparam logic [2:0] OUT_TIE         = 3'd3;

  // Controller states; code 2'd3 is unused and recovers to ST_PLAY
  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Cell indices, row-major
  localparam logic [3:0] POS_A1 = 4'd0;
  localparam logic [3:0] POS_A2 = 4'd1;
  localparam logic [3:0] POS_A3 = 4'd2;
  localparam logic [3:0] POS_B1 = 4'd3;
  localparam logic [3:0] POS_B2 = 4'd4;
  localparam logic [3:0] POS_B3 = 4'd5;
  localparam logic [3:0] POS_C1 = 4'd6;
  localparam logic [3:0] POS_C2 = 4'd7;
  localparam logic [3:0] POS_C3 = 4'd8;

  localparam int unsigned NUM_CELLS = 9;
  localparam logic [3:0]  MAX_MOVES = 4'd9;

  // Opponent of the given player code; anything unexpected maps to P1
  function automatic logic [1:0] other_player(input logic [1:0] player);
    logic [1:0] result;
    case (player)
      CELL_P1: result = CELL_P2;
      CELL_P2: result = CELL_P1;
      default: result = CELL_P1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ttt_cell_decode.sv
// -----------------------------------------------------------------------------
// ttt_cell_decode
// Maps a 4-bit cell index to a 9-bit one-hot write-enable vector plus an
// out-of-range flag for indices 9..15 (which produce an all-zero vector).
// Ports:
//   move_pos     in  4  requested cell index (0=A1 .. 8=C3)
//   cell_sel     out 9  one-hot cell select, bit i <=> cell i
//   out_of_range out 1  move_pos > 8
// -----------------------------------------------------------------------------
module ttt_cell_decode
  import ttt_board_ctrl_pkg::*;
(
  input  logic [3:0] move_pos,
  output logic [8:0] cell_sel,
  output logic       out_of_range
);

  // One-hot decode of the requested cell index
  always_comb begin
    cell_sel     = 9'd0;
    out_of_range = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      cell_sel[i] = (move_pos == 4'(i));
    end
    if (move_pos > POS_C3) begin
      out_of_range = 1'b1;
    end else begin
      out_of_range = 1'b0;
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// -----------------------------------------------------------------------------
// ttt_board_ctrl
// Board/turn controller for tic-tac-toe. Holds the nine cells, validates move
// requests, alternates players and reads back the combinational checker's
// outcome one cycle after each accepted move. Freezes the board once the
// checker reports a win, loss or tie.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   new_game              one-cycle request: clear board and restart
//   move_valid, move_pos  move request strobe and target cell index
//   outcome_in            checker outcome (0 in progress, 1 win, 2 lose, 3 tie)
//   grid_A1 .. grid_C3    registered cell contents
//   turn                  code of the player to move
//   move_ready            a move will be accepted this cycle
//   move_err              one-cycle pulse after a rejected move
//   move_count            accepted moves, saturating at 9
//   game_over, result     DONE flag and outcome latched on entry to DONE
// -----------------------------------------------------------------------------
module ttt_board_ctrl
  import ttt_board_ctrl_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic [2:0] outcome_in,
  output logic [1:0] grid_A1,
  output logic [1:0] grid_A2,
  output logic [1:0] grid_A3,
  output logic [1:0] grid_B1,
  output logic [1:0] grid_B2,
  output logic [1:0] grid_B3,
  output logic [1:0] grid_C1,
  output logic [1:0] grid_C2,
  output logic [1:0] grid_C3,
  output logic [1:0] turn,
  output logic       move_ready,
  output logic       move_err,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [2:0] result
);

  state_t     state_r, next_state_s;
  logic [1:0] cells_r   [NUM_CELLS];
  logic [1:0] cells_nxt_s [NUM_CELLS];
  logic [1:0] turn_r, turn_nxt_s;
  logic [3:0] count_r, count_nxt_s;
  logic       err_r, err_nxt_s;
  logic       game_over_r, game_over_nxt_s;
  logic [2:0] result_r, result_nxt_s;
  logic       ready_r;

  logic [8:0] cell_sel_s;
  logic       out_of_range_s;
  logic       target_empty_s;
  logic       legal_s;
  logic       illegal_s;

  ttt_cell_decode u_cell_decode (
    .move_pos     (move_pos),
    .cell_sel     (cell_sel_s),
    .out_of_range (out_of_range_s)
  );

  // Classify the current request; only meaningful while in PLAY
  always_comb begin
    target_empty_s = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      target_empty_s = target_empty_s | (cell_sel_s[i] & (cells_r[i] == CELL_EMPTY));
    end
    legal_s   = move_valid & ~out_of_range_s & target_empty_s;
    illegal_s = move_valid & (out_of_range_s | ~target_empty_s);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_PLAY;
      ready_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == ST_PLAY);
    end
  end

  // Next-state logic; new_game always returns to PLAY
  always_comb begin
    next_state_s = ST_PLAY;
    if (new_game) begin
      next_state_s = ST_PLAY;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (legal_s) begin
            next_state_s = ST_CHECK;
          end else begin
            next_state_s = ST_PLAY;
          end
        end
        ST_CHECK: begin
          if (outcome_in != OUT_IN_PROGRESS) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_PLAY;
          end
        end
        ST_DONE:  next_state_s = ST_DONE;
        default:  next_state_s = ST_PLAY;
      endcase
    end
  end

  // Next values of the board, turn, counters and status outputs
  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      cells_nxt_s[i] = cells_r[i];
    end
    turn_nxt_s      = turn_r;
    count_nxt_s     = count_r;
    err_nxt_s       = 1'b0;
    game_over_nxt_s = game_over_r;
    result_nxt_s    = result_r;
    if (new_game) begin
      // Clear exactly as reset does; a simultaneous move is dropped silently
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells_nxt_s[i] = CELL_EMPTY;
      end
      turn_nxt_s      = FIRST_PLAYER;
      count_nxt_s     = 4'd0;
      game_over_nxt_s = 1'b0;
      result_nxt_s    = OUT_IN_PROGRESS;
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (legal_s) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
              if (cell_sel_s[i]) begin
                cells_nxt_s[i] = turn_r;
              end else begin
                cells_nxt_s[i] = cells_r[i];
              end
            end
            count_nxt_s = (count_r == MAX_MOVES) ? count_r : (count_r + 4'd1);
          end else if (illegal_s) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b0;
          end
        end
        ST_CHECK: begin
          // Turn stays with the player who just ended the game
          if (outcome_in != OUT_IN_PROGRESS) begin
            game_over_nxt_s = 1'b1;
            result_nxt_s    = outcome_in;
          end else begin
            turn_nxt_s = other_player(turn_r);
          end
        end
        ST_DONE: begin
          if (move_valid) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b0;
          end
        end
        default: err_nxt_s = 1'b0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells_r[i] <= CELL_EMPTY;
      end
      turn_r      <= FIRST_PLAYER;
      count_r     <= 4'd0;
      err_r       <= 1'b0;
      game_over_r <= 1'b0;
      result_r    <= OUT_IN_PROGRESS;
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells_r[i] <= cells_nxt_s[i];
      end
      turn_r      <= turn_nxt_s;
      count_r     <= count_nxt_s;
      err_r       <= err_nxt_s;
      game_over_r <= game_over_nxt_s;
      result_r    <= result_nxt_s;
    end
  end

  assign grid_A1    = cells_r[0];
  assign grid_A2    = cells_r[1];
  assign grid_A3    = cells_r[2];
  assign grid_B1    = cells_r[3];
  assign grid_B2    = cells_r[4];
  assign grid_B3    = cells_r[5];
  assign grid_C1    = cells_r[6];
  assign grid_C2    = cells_r[7];
  assign grid_C3    = cells_r[8];
  assign turn       = turn_r;
  assign move_ready = ready_r;
  assign move_err   = err_r;
  assign move_count = count_r;
  assign game_over  = game_over_r;
  assign result     = result_r;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ttt_board_ctrl
// Directed self-checking bench for ttt_board_ctrl. The bench plays the role of
// the checker by driving outcome_in during the CHECK cycle of each move.
// -----------------------------------------------------------------------------
module tb_ttt_board_ctrl;

  logic       clk;
  logic       reset;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_pos;
  logic [2:0] outcome_in;
  logic [1:0] grid_A1, grid_A2, grid_A3;
  logic [1:0] grid_B1, grid_B2, grid_B3;
  logic [1:0] grid_C1, grid_C2, grid_C3;
  logic [1:0] turn;
  logic       move_ready;
  logic       move_err;
  logic [3:0] move_count;
  logic       game_over;
  logic [2:0] result;

  int n_checks = 0;
  int n_errors = 0;

  ttt_board_ctrl #(.FIRST_PLAYER(2'b01)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .outcome_in (outcome_in),
    .grid_A1    (grid_A1),
    .grid_A2    (grid_A2),
    .grid_A3    (grid_A3),
    .grid_B1    (grid_B1),
    .grid_B2    (grid_B2),
    .grid_B3    (grid_B3),
    .grid_C1    (grid_C1),
    .grid_C2    (grid_C2),
    .grid_C3    (grid_C3),
    .turn       (turn),
    .move_ready (move_ready),
    .move_err   (move_err),
    .move_count (move_count),
    .game_over  (game_over),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole board packed with A1 in the two LSBs
  function automatic logic [17:0] grid_vec();
    return {grid_C3, grid_C2, grid_C1, grid_B3, grid_B2, grid_B1, grid_A3, grid_A2, grid_A1};
  endfunction

  // Expected contribution of one cell to the packed board
  function automatic logic [17:0] cv(input int pos, input logic [1:0] code);
    logic [17:0] v;
    v = {16'd0, code};
    return v << (2 * pos);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Legal move: one accept cycle, then CHECK with the given checker outcome
  task automatic do_move(input logic [3:0] pos, input logic [2:0] outc);
    move_valid = 1'b1;
    move_pos   = pos;
    step();
    move_valid = 1'b0;
    outcome_in = outc;
    step();
    outcome_in = 3'd0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  initial begin
    logic [17:0] exp_g;
    reset      = 1'b1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    outcome_in = 3'd0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_grid",  32'(grid_vec()), 32'd0);
    check_eq("rst_turn",  32'(turn), 32'd1);
    check_eq("rst_count", 32'(move_count), 32'd0);
    check_eq("rst_ready", 32'(move_ready), 32'd1);
    check_eq("rst_err",   32'(move_err), 32'd0);
    check_eq("rst_over",  32'(game_over), 32'd0);
    check_eq("rst_res",   32'(result), 32'd0);

    // P1 takes B2: cell visible next edge, turn toggles one edge later
    move_valid = 1'b1;
    move_pos   = 4'd4;
    step();
    move_valid = 1'b0;
    check_eq("m1_b2",    32'(grid_B2), 32'd1);
    check_eq("m1_count", 32'(move_count), 32'd1);
    check_eq("m1_ready_chk", 32'(move_ready), 32'd0);
    check_eq("m1_turn_chk",  32'(turn), 32'd1);
    step();
    check_eq("m1_turn",  32'(turn), 32'd2);
    check_eq("m1_ready", 32'(move_ready), 32'd1);

    // P2 tries occupied B2
    move_valid = 1'b1;
    move_pos   = 4'd4;
    step();
    move_valid = 1'b0;
    check_eq("occ_err",   32'(move_err), 32'd1);
    check_eq("occ_b2",    32'(grid_B2), 32'd1);
    check_eq("occ_turn",  32'(turn), 32'd2);
    check_eq("occ_count", 32'(move_count), 32'd1);
    step();
    check_eq("occ_err_end", 32'(move_err), 32'd0);

    // Out-of-range index
    move_valid = 1'b1;
    move_pos   = 4'd12;
    step();
    move_valid = 1'b0;
    check_eq("oor_err",  32'(move_err), 32'd1);
    check_eq("oor_grid", 32'(grid_vec()), 32'(cv(4, 2'b01)));
    step();
    check_eq("oor_err_end", 32'(move_err), 32'd0);

    // new_game together with a legal move: clear, no write, no error
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd0;
    step();
    new_game   = 1'b0;
    move_valid = 1'b0;
    check_eq("ng_grid",  32'(grid_vec()), 32'd0);
    check_eq("ng_turn",  32'(turn), 32'd1);
    check_eq("ng_err",   32'(move_err), 32'd0);
    check_eq("ng_count", 32'(move_count), 32'd0);
    check_eq("ng_ready", 32'(move_ready), 32'd1);

    // P1 A1, with move_valid held to C3 during CHECK (must be ignored)
    move_valid = 1'b1;
    move_pos   = 4'd0;
    step();
    move_pos   = 4'd8;
    step();
    move_valid = 1'b0;
    check_eq("chk_ign_err",  32'(move_err), 32'd0);
    check_eq("chk_ign_grid", 32'(grid_vec()), 32'(cv(0, 2'b01)));
    check_eq("chk_ign_turn", 32'(turn), 32'd2);

    // Remaining moves 3,1,4,2; checker reports P1 win after the last
    do_move(4'd3, 3'd0);
    do_move(4'd1, 3'd0);
    do_move(4'd4, 3'd0);
    do_move(4'd2, 3'd1);
    exp_g = cv(0, 2'b01) | cv(3, 2'b10) | cv(1, 2'b01) | cv(4, 2'b10) | cv(2, 2'b01);
    check_eq("win_over",  32'(game_over), 32'd1);
    check_eq("win_res",   32'(result), 32'd1);
    check_eq("win_count", 32'(move_count), 32'd5);
    check_eq("win_ready", 32'(move_ready), 32'd0);
    check_eq("win_turn",  32'(turn), 32'd1);
    check_eq("win_grid",  32'(grid_vec()), 32'(exp_g));

    // Move in DONE is rejected, board frozen
    move_valid = 1'b1;
    move_pos   = 4'd8;
    step();
    move_valid = 1'b0;
    check_eq("done_err", 32'(move_err), 32'd1);
    check_eq("done_c3",  32'(grid_C3), 32'd0);
    step();
    check_eq("done_err_end", 32'(move_err), 32'd0);
    check_eq("done_over",    32'(game_over), 32'd1);

    // new_game from DONE
    pulse_new_game();
    check_eq("ng2_over",  32'(game_over), 32'd0);
    check_eq("ng2_res",   32'(result), 32'd0);
    check_eq("ng2_grid",  32'(grid_vec()), 32'd0);
    check_eq("ng2_ready", 32'(move_ready), 32'd1);

    // Nine-move tie: P1 0,2,3,7,8 / P2 1,4,5,6
    do_move(4'd0, 3'd0);
    do_move(4'd1, 3'd0);
    do_move(4'd2, 3'd0);
    do_move(4'd4, 3'd0);
    do_move(4'd3, 3'd0);
    do_move(4'd5, 3'd0);
    do_move(4'd7, 3'd0);
    do_move(4'd6, 3'd0);
    do_move(4'd8, 3'd3);
    exp_g = cv(0, 2'b01) | cv(2, 2'b01) | cv(3, 2'b01) | cv(7, 2'b01) | cv(8, 2'b01)
          | cv(1, 2'b10) | cv(4, 2'b10) | cv(5, 2'b10) | cv(6, 2'b10);
    check_eq("tie_res",   32'(result), 32'd3);
    check_eq("tie_over",  32'(game_over), 32'd1);
    check_eq("tie_count", 32'(move_count), 32'd9);
    check_eq("tie_grid",  32'(grid_vec()), 32'(exp_g));

    // Reset during CHECK discards the pending win
    pulse_new_game();
    move_valid = 1'b1;
    move_pos   = 4'd5;
    step();
    move_valid = 1'b0;
    check_eq("rchk_b3", 32'(grid_B3), 32'd1);
    reset      = 1'b1;
    outcome_in = 3'd1;
    step();
    reset      = 1'b0;
    outcome_in = 3'd0;
    check_eq("rchk_grid",  32'(grid_vec()), 32'd0);
    check_eq("rchk_turn",  32'(turn), 32'd1);
    check_eq("rchk_count", 32'(move_count), 32'd0);
    check_eq("rchk_over",  32'(game_over), 32'd0);
    check_eq("rchk_res",   32'(result), 32'd0);
    check_eq("rchk_err",   32'(move_err), 32'd0);
    step();
    check_eq("rchk_ready", 32'(move_ready), 32'd1);

    // Nine moves with no outcome: stay in PLAY, count saturates, board full
    for (int i = 0; i < 9; i++) begin
      do_move(4'(i), 3'd0);
    end
    check_eq("sat_count", 32'(move_count), 32'd9);
    check_eq("sat_over",  32'(game_over), 32'd0);
    check_eq("sat_ready", 32'(move_ready), 32'd1);
    check_eq("sat_turn",  32'(turn), 32'd2);
    move_valid = 1'b1;
    move_pos   = 4'd3;
    step();
    move_valid = 1'b0;
    check_eq("sat_err",    32'(move_err), 32'd1);
    check_eq("sat_count2", 32'(move_count), 32'd9);
    check_eq("sat_b1",     32'(grid_B1), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
